// File: rtl/axis2model_pkg.sv
// Shared definitions for the AXIS command adapter: command word layout, opcodes,
// FSM state encoding and the response word packer.
package axis2model_pkg;

  localparam int CMD_W    = 32;
  localparam int OPC_W    = 8;
  localparam int ADDR_FW  = 16;
  localparam int DATA_FW  = 8;
  localparam int OPC_LSB  = 24;
  localparam int ADDR_LSB = 8;
  localparam int DATA_LSB = 0;
  localparam int HDR_ID_W = 16;

  localparam logic [OPC_W-1:0] OP_HDR = 8'h80;
  localparam logic [OPC_W-1:0] OP_WR  = 8'h02;
  localparam logic [OPC_W-1:0] OP_RD  = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Response words share the command layout: opcode, 16-bit middle field, data byte.
  function automatic logic [CMD_W-1:0] pack_resp(
    input logic [OPC_W-1:0]   op,
    input logic [ADDR_FW-1:0] mid,
    input logic [DATA_FW-1:0] lo
  );
    pack_resp = {op, mid, lo};
  endfunction

endpackage

// File: rtl/axis2model_cmd_decoder.sv
// Combinational split of a 32-bit command word into its fields and a one-hot
// opcode classification.
module axis2model_cmd_decoder
  import axis2model_pkg::*;
(
  input  logic [CMD_W-1:0]   word,
  output logic [OPC_W-1:0]   opcode,
  output logic [ADDR_FW-1:0] addr,
  output logic [DATA_FW-1:0] data,
  output logic               is_hdr,
  output logic               is_wr,
  output logic               is_rd,
  output logic               is_unknown
);

  assign opcode = word[OPC_LSB  +: OPC_W];
  assign addr   = word[ADDR_LSB +: ADDR_FW];
  assign data   = word[DATA_LSB +: DATA_FW];

  // Opcode classification; exactly one flag is high for any word.
  always_comb begin
    is_hdr     = 1'b0;
    is_wr      = 1'b0;
    is_rd      = 1'b0;
    is_unknown = 1'b0;
    case (opcode)
      OP_HDR:  is_hdr     = 1'b1;
      OP_WR:   is_wr      = 1'b1;
      OP_RD:   is_rd      = 1'b1;
      default: is_unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/axis_to_model_if.sv
// AXIS command stream to single-port byte memory adapter with 32-bit responses.
// Optional AXIS2MODEL_WR_ECHO_EN: every WRITE also returns an echo response.
module axis_to_model_if
  import axis2model_pkg::*;
#(
  parameter int ADDR_W = ADDR_FW,
  parameter int DATA_W = DATA_FW
) (
  input  logic              core_clk,
  input  logic              rst_n,
  input  logic [CMD_W-1:0]  gtp2core_tdata,
  input  logic              gtp2core_tvalid,
  output logic              gtp2core_tready,
  input  logic              gtp2core_tlast,
  output logic              ena_model,
  output logic              wea_model,
  output logic [ADDR_W-1:0] addra_model,
  output logic [DATA_W-1:0] dina_model,
  input  logic [DATA_W-1:0] douta_model,
  output logic [CMD_W-1:0]  dut_data,
  output logic              dut_valid
);

  state_t state_r, state_nxt;

  logic              tready_r, tready_nxt;
  logic              ena_r, ena_nxt;
  logic              wea_r, wea_nxt;
  logic [ADDR_W-1:0] addra_r, addra_nxt;
  logic [DATA_W-1:0] dina_r, dina_nxt;
  logic [CMD_W-1:0]  dut_data_r, dut_data_nxt;
  logic              dut_valid_r, dut_valid_nxt;
  logic [HDR_ID_W-1:0] test_id_r, test_id_nxt;

  logic [OPC_W-1:0]   dec_opcode_s;
  logic [ADDR_FW-1:0] dec_addr_s;
  logic [DATA_FW-1:0] dec_data_s;
  logic               dec_hdr_s, dec_wr_s, dec_rd_s, dec_unknown_s;
  logic               accept_s;
  logic               unused_s;

  axis2model_cmd_decoder u_dec (
    .word       (gtp2core_tdata),
    .opcode     (dec_opcode_s),
    .addr       (dec_addr_s),
    .data       (dec_data_s),
    .is_hdr     (dec_hdr_s),
    .is_wr      (dec_wr_s),
    .is_rd      (dec_rd_s),
    .is_unknown (dec_unknown_s)
  );

  // tlast is reserved; unknown opcodes fall through the IDLE else-branch.
  assign unused_s = ^{gtp2core_tlast, dec_opcode_s, dec_unknown_s};
  assign accept_s = gtp2core_tvalid & tready_r;

  // State register.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next state and next registered output values.
  always_comb begin
    state_nxt     = state_r;
    ena_nxt       = 1'b0;
    wea_nxt       = 1'b0;
    addra_nxt     = addra_r;
    dina_nxt      = dina_r;
    dut_valid_nxt = 1'b0;
    dut_data_nxt  = dut_data_r;
    test_id_nxt   = test_id_r;
    tready_nxt    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (dec_hdr_s) begin
            test_id_nxt   = gtp2core_tdata[HDR_ID_W-1:0];
            dut_data_nxt  = {OP_HDR, 8'h00, gtp2core_tdata[HDR_ID_W-1:0]};
            dut_valid_nxt = 1'b1;
            state_nxt     = ST_RESP;
          end else if (dec_wr_s) begin
            ena_nxt   = 1'b1;
            wea_nxt   = 1'b1;
            addra_nxt = dec_addr_s;
            dina_nxt  = dec_data_s;
            state_nxt = ST_EXEC;
          end else if (dec_rd_s) begin
            ena_nxt   = 1'b1;
            addra_nxt = dec_addr_s;
            state_nxt = ST_EXEC;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: begin
        // wea_r still holds the pulse issued on entry, so it tells WRITE from READ.
        if (wea_r) begin
`ifdef AXIS2MODEL_WR_ECHO_EN
          dut_data_nxt  = pack_resp(OP_WR, addra_r, dina_r);
          dut_valid_nxt = 1'b1;
          state_nxt     = ST_RESP;
`else
          state_nxt     = ST_IDLE;
`endif
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        dut_data_nxt  = pack_resp(OP_RD, addra_r, douta_model);
        dut_valid_nxt = 1'b1;
        state_nxt     = ST_RESP;
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    tready_nxt = (state_nxt == ST_IDLE);
  end

  // Output and context registers.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      tready_r    <= 1'b0;
      ena_r       <= 1'b0;
      wea_r       <= 1'b0;
      addra_r     <= {ADDR_W{1'b0}};
      dina_r      <= {DATA_W{1'b0}};
      dut_data_r  <= {CMD_W{1'b0}};
      dut_valid_r <= 1'b0;
      test_id_r   <= {HDR_ID_W{1'b0}};
    end else begin
      tready_r    <= tready_nxt;
      ena_r       <= ena_nxt;
      wea_r       <= wea_nxt;
      addra_r     <= addra_nxt;
      dina_r      <= dina_nxt;
      dut_data_r  <= dut_data_nxt;
      dut_valid_r <= dut_valid_nxt;
      test_id_r   <= test_id_nxt;
    end
  end

  assign gtp2core_tready = tready_r;
  assign ena_model       = ena_r;
  assign wea_model       = wea_r;
  assign addra_model     = addra_r;
  assign dina_model      = dina_r;
  assign dut_data        = dut_data_r;
  assign dut_valid       = dut_valid_r;

endmodule

// File: tb/tb_axis_to_model_if.sv
// Scoreboard bench for axis_to_model_if with a behavioural 64K x 8 memory model.
module tb_axis_to_model_if;

  logic        core_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] gtp2core_tdata = 32'h0;
  logic        gtp2core_tvalid = 1'b0;
  logic        gtp2core_tready;
  logic        gtp2core_tlast = 1'b0;
  logic        ena_model, wea_model;
  logic [15:0] addra_model;
  logic [7:0]  dina_model;
  logic [7:0]  douta_model = 8'h00;
  logic [31:0] dut_data;
  logic        dut_valid;

  axis_to_model_if dut (
    .core_clk        (core_clk),
    .rst_n           (rst_n),
    .gtp2core_tdata  (gtp2core_tdata),
    .gtp2core_tvalid (gtp2core_tvalid),
    .gtp2core_tready (gtp2core_tready),
    .gtp2core_tlast  (gtp2core_tlast),
    .ena_model       (ena_model),
    .wea_model       (wea_model),
    .addra_model     (addra_model),
    .dina_model      (dina_model),
    .douta_model     (douta_model),
    .dut_data        (dut_data),
    .dut_valid       (dut_valid)
  );

  always #5 core_clk = ~core_clk;

  int cyc = 0;
  always @(posedge core_clk) cyc <= cyc + 1;

  logic [7:0] mem [0:65535];
  always @(posedge core_clk) begin
    if (ena_model) begin
      if (wea_model) mem[addra_model] <= dina_model;
      douta_model <= mem[addra_model];
    end
  end

  typedef struct {
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int resp_cnt = 0;
  int ena_cnt = 0;
  int wea_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response strobe is seen.
  initial begin
    exp_t e;
    forever begin
      @(negedge core_clk);
      if (ena_model) ena_cnt++;
      if (wea_model) wea_cnt++;
      if (dut_valid) begin
        resp_cnt++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_resp: got %h with nothing expected at cycle %0d", dut_data, cyc);
        end else begin
          e = exp_q.pop_front();
          if (dut_data !== e.data || cyc != e.at) begin
            fails++;
            $display("FAIL resp: got %h at cycle %0d, expected %h at cycle %0d", dut_data, cyc, e.data, e.at);
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] w, input bit has_resp, input logic [31:0] resp,
                      input int lat, input int busy_exp, input bit exp_ena, input bit exp_wea);
    int acc;
    int busy;
    int guard;
    exp_t e;
    gtp2core_tdata  = w;
    gtp2core_tvalid = 1'b1;
    guard = 0;
    while (!gtp2core_tready && guard < 20) begin
      @(negedge core_clk); #1;
      guard++;
    end
    if (!gtp2core_tready) begin
      chk("accept_timeout", 64'(gtp2core_tready), 64'd1);
      gtp2core_tvalid = 1'b0;
      return;
    end
    acc = cyc;
    if (has_resp) begin
      e.data = resp;
      e.at   = acc + lat;
      exp_q.push_back(e);
    end
    @(negedge core_clk); #1;
    chk("ena_wea", {62'd0, ena_model, wea_model}, {62'd0, exp_ena, exp_wea});
    if (exp_ena) chk("addra", 64'(addra_model), 64'(w[23:8]));
    busy = 0;
    while (!gtp2core_tready && busy < 16) begin
      @(negedge core_clk); #1;
      busy++;
    end
    chk("busy_cycles", 64'(busy), 64'(busy_exp));
    gtp2core_tvalid = 1'b0;
  endtask

  task automatic wr(input logic [31:0] w, input logic [31:0] echo);
`ifdef AXIS2MODEL_WR_ECHO_EN
    send(w, 1'b1, echo, 2, 2, 1'b1, 1'b1);
`else
    send(w, 1'b0, echo, 0, 1, 1'b1, 1'b1);
`endif
  endtask

  task automatic rd(input logic [31:0] w, input logic [31:0] resp);
    send(w, 1'b1, resp, 3, 3, 1'b1, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int w0;
    int r0;
    repeat (25) @(negedge core_clk);
    #1;
    chk("reset_outputs", {23'd0, gtp2core_tready, ena_model, wea_model, addra_model, dina_model, dut_valid},
        64'd0);
    chk("reset_dut_data", 64'(dut_data), 64'd0);
    repeat (25) @(negedge core_clk);
    rst_n = 1'b1;
    #1;
    chk("tready_at_release", 64'(gtp2core_tready), 64'd0);
    @(negedge core_clk); #1;
    chk("tready_after_release", 64'(gtp2core_tready), 64'd1);

    e0 = ena_cnt;
    send(32'h80000005, 1'b1, 32'h80000005, 1, 1, 1'b0, 1'b0);
    send(32'h80FF1234, 1'b1, 32'h80001234, 1, 1, 1'b0, 1'b0);
    chk("hdr_no_ena", 64'(ena_cnt - e0), 64'd0);

    w0 = wea_cnt;
    wr(32'h02000000, 32'h02000000);
    wr(32'h020000FF, 32'h020000FF);
    rd(32'h03000000, 32'h030000FF);
    chk("two_write_pulses", 64'(wea_cnt - w0), 64'd2);

    wr(32'h020001FF, 32'h020001FF);
    wr(32'h02000100, 32'h02000100);
    rd(32'h03000100, 32'h03000100);

    wr(32'h02000000, 32'h02000000);
    rd(32'h03000000, 32'h03000000);
    rd(32'h03000000, 32'h03000000);

    wr(32'h02ABCD5A, 32'h02ABCD5A);
    rd(32'h03ABCD00, 32'h03ABCD5A);
    rd(32'h030000FF, 32'h03000000);

    e0 = ena_cnt;
    r0 = resp_cnt;
    send(32'h55001234, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge core_clk);
    #1;
    chk("unknown_no_ena", 64'(ena_cnt - e0), 64'd0);
    chk("unknown_no_resp", 64'(resp_cnt - r0), 64'd0);

    // Reset asserted while the read sits in WAIT.
    r0 = resp_cnt;
    gtp2core_tdata  = 32'h03ABCD00;
    gtp2core_tvalid = 1'b1;
    chk("wait_case_tready", 64'(gtp2core_tready), 64'd1);
    @(negedge core_clk); #1;
    gtp2core_tvalid = 1'b0;
    chk("wait_case_ena", 64'(ena_model), 64'd1);
    @(negedge core_clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {23'd0, gtp2core_tready, ena_model, wea_model, addra_model, dina_model, dut_valid},
        64'd0);
    chk("midreset_dut_data", 64'(dut_data), 64'd0);
    repeat (3) @(negedge core_clk);
    rst_n = 1'b1;
    @(negedge core_clk); #1;
    chk("midreset_tready", 64'(gtp2core_tready), 64'd1);
    chk("midreset_no_resp", 64'(resp_cnt - r0), 64'd0);

    rd(32'h03ABCD00, 32'h03ABCD5A);
    send(32'h8000BEEF, 1'b1, 32'h8000BEEF, 1, 1, 1'b0, 1'b0);

    repeat (5) @(negedge core_clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_to_model_if.md
# axis_to_model_if

Command-stream adapter between the GTP receive path and the byte-wide DUT memory model. It accepts 32-bit command words on an AXI-Stream slave port, fed by a small AXIS FIFO. It decodes each word into a single-port block-RAM access on the memory model (64K x 8, 1-cycle read latency) and returns read results and header echoes as 32-bit response words on `dut_data`/`dut_valid`.

## Interface
- `ADDR_W`, 16, memory address width.
- `DATA_W`, 8, memory data width.
- `core_clk`  in  1  the single clock.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `gtp2core_tdata`  in  32  command word.
- `gtp2core_tvalid`  in  1  command valid.
- `gtp2core_tready`  out  1  command accepted when high with tvalid.
- `gtp2core_tlast`  in  1  reserved; ignored; may be left unconnected.
- `ena_model`  out  1  memory enable.
- `wea_model`  out  1  memory write enable.
- `addra_model`  out  ADDR_W  memory address.
- `dina_model`  out  DATA_W  memory write data.
- `douta_model`  in  DATA_W  memory read data; valid 1 cycle after the read enable.
- `dut_data`  out  32  response word.
- `dut_valid`  out  1  one-cycle response strobe.

## Operation
- Command fields: opcode = [31:24], addr = [23:8], data = [7:0].
- Opcode 0x80, HEADER:
  - Latch test_id = [15:0].
  - Emit response {8'h80, 8'h00, test_id}.
- Opcode 0x02, WRITE: mem[addr] <= data.
- Opcode 0x03, READ: read mem[addr] and emit response {8'h03, addr, douta}.
- Any other opcode: consumed and dropped. No memory access, no response.
- FSM states: IDLE, EXEC, WAIT, RESP.
  - IDLE: tready=1. Word accepted on tvalid&tready and registered.
  - HEADER goes IDLE->RESP.
  - WRITE goes IDLE->EXEC->IDLE.
  - READ goes IDLE->EXEC->WAIT->RESP->IDLE.
  - Unknown opcode goes IDLE->IDLE.
- EXEC: ena=1, addra=addr. For WRITE also wea=1 and dina=data; for READ wea=0.
- WAIT: douta captured at the end of this state.
- RESP: dut_valid=1 for exactly one cycle, with dut_data as defined above.
- No output backpressure exists on the response path. The downstream consumer must always accept `dut_valid`.

## Timing
- Reset values:
  - tready=0, ena=0, wea=0, addra=0, dina=0, dut_data=0, dut_valid=0, test_id=0.
  - FSM state is IDLE.
- tready is 1 only in IDLE; it rises in the first cycle after reset deasserts.
- All outputs are registered.
- WRITE accepted at cycle N:
  - ena=wea=1 at N+1.
  - tready=1 again at N+2.
- READ accepted at cycle N:
  - ena=1 at N+1; douta is sampled at N+2.
  - dut_valid=1 at N+3.
  - tready=1 at N+4.
- HEADER accepted at cycle N: dut_valid at N+1, tready=1 at N+2.
- ena/wea are single-cycle pulses.
- addra and dina hold their last values while ena=0.
- Back-to-back commands are accepted only in IDLE. tvalid held high across a busy period causes no loss or duplication.
- Reset asserted mid-operation:
  - The current command is aborted and outputs return to their reset values immediately.
  - A write already pulsed is not undone.
- A read of an address written earlier returns the last written data (write-then-read ordering is guaranteed by the FSM).

## Configuration
- `AXIS2MODEL_WR_ECHO_EN`:
  - Defined: every WRITE also emits response {8'h02, addr, data}. WRITE then goes IDLE->EXEC->RESP->IDLE, with dut_valid at N+2 and tready at N+3.
  - Undefined: WRITE produces no response, as specified above.

## Structure
- Shared package `axis2model_pkg` holds:
  - opcode constants OP_HDR=8'h80, OP_WR=8'h02, OP_RD=8'h03;
  - field widths and bit positions;
  - the FSM state enum.
- One sub-module `axis2model_cmd_decoder`: combinational split of a 32-bit word into opcode/addr/data plus is_hdr/is_wr/is_rd/is_unknown flags.
- FIFO and memory model are external. The only assumptions are 1-cycle BRAM read latency and standard AXIS FIFO semantics.

## Test plan
- Reset for 50 cycles:
  - all outputs 0 during reset;
  - tready=1 one cycle after release.
- 0x80000005:
  - dut_data=0x80000005, one dut_valid pulse;
  - no ena activity.
- Write then read:
  - 0x02000000, then 0x020000FF, then 0x03000000;
  - two write pulses to addr 0;
  - one response 0x030000FF at accept+3.
- Write then read, address 1:
  - 0x020001FF, then 0x02000100, then 0x03000100;
  - response 0x03000100.
- Back-to-back reads:
  - 0x02000000, then 0x03000000 twice through the FIFO;
  - two responses 0x03000000;
  - tready low 3 cycles per read, no word lost.
- Unknown and reset cases:
  - 0x55001234 produces no ena and no dut_valid, and tready returns next cycle;
  - rst_n pulsed low during WAIT gives no dut_valid and outputs 0.
